// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Holds the operation encoding, flag payload and signed range bounds.
package addsub_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_SUB     = 2'd0,
    OP_ADD     = 2'd1,
    OP_RSUB    = 2'd2,
    OP_ABSDIFF = 2'd3
  } op_e;

  typedef struct packed {
    logic cb;
    logic ovf;
  } flags_t;

  // Largest two's-complement value of a w-bit word, zero-padded to MAX_W.
  function automatic logic [MAX_W-1:0] smax_bound(input int unsigned w);
    return (64'd1 << (w - 32'd1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word, zero-padded to MAX_W.
  function automatic logic [MAX_W-1:0] smin_bound(input int unsigned w);
    return 64'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational raw result, borrow/carry, overflow and clamp value for one
// add/subtract transaction; saturation itself is applied by the caller.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             sgn,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] sat_val,
  output logic             cb,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_bound(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_bound(WIDTH));

  logic [WIDTH:0]   ea_s;
  logic [WIDTH:0]   eb_s;
  logic [WIDTH:0]   raw_s;
  logic [WIDTH-1:0] lsum_s;
  logic             lt_ab_s;
  logic             lt_ba_s;
  logic             carry_s;

  // Operand extension, ordering under the selected signedness, unsigned carry
  always_comb begin
    if (sgn) begin
      ea_s = {a[WIDTH-1], a};
      eb_s = {b[WIDTH-1], b};
    end else begin
      ea_s = {1'b0, a};
      eb_s = {1'b0, b};
    end
    lt_ab_s = $signed(ea_s) < $signed(eb_s);
    lt_ba_s = $signed(eb_s) < $signed(ea_s);
    lsum_s  = a + b;
    carry_s = (lsum_s < a);
  end

  // WIDTH+1 bits hold every true sum/difference, so overflow is read off the top bits
  always_comb begin
    raw_s   = {(WIDTH+1){1'b0}};
    cb      = 1'b0;
    ovf     = 1'b0;
    sat_val = {WIDTH{1'b0}};
    case (op)
      OP_SUB: begin
        raw_s = ea_s - eb_s;
        cb    = lt_ab_s;
      end
      OP_ADD: begin
        raw_s = ea_s + eb_s;
        cb    = carry_s;
      end
      OP_RSUB: begin
        raw_s = eb_s - ea_s;
        cb    = lt_ba_s;
      end
      OP_ABSDIFF: begin
        if (lt_ab_s) begin
          raw_s = eb_s - ea_s;
        end else begin
          raw_s = ea_s - eb_s;
        end
        cb = lt_ab_s;
      end
      default: begin
        raw_s = {(WIDTH+1){1'b0}};
        cb    = 1'b0;
      end
    endcase

    if (op == OP_ABSDIFF) begin
      ovf = 1'b0;
    end else if (sgn) begin
      ovf = raw_s[WIDTH] ^ raw_s[WIDTH-1];
    end else begin
      ovf = raw_s[WIDTH];
    end

    if (sgn) begin
      sat_val = raw_s[WIDTH] ? SMIN : SMAX;
    end else if (op == OP_ADD) begin
      sat_val = {WIDTH{1'b1}};
    end else begin
      sat_val = {WIDTH{1'b0}};
    end

    res = raw_s[WIDTH-1:0];
  end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/subtract unit with valid/ready on both sides.
// Stage 1 holds operands and feeds the core; stage 2 holds the saturated result.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit SAT_DEFAULT = 1'b0,
  parameter bit SAT_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cb,
  output logic             out_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    flags_t           flags;
  } payload_t;

  logic             v1_r;
  logic             v2_r;
  logic [WIDTH-1:0] a1_r;
  logic [WIDTH-1:0] b1_r;
  op_e              op1_r;
  logic             sgn1_r;
  logic             sat1_r;
  payload_t         out_r;
  payload_t         out_nxt_s;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             sat_sel_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] sat_val_s;
  logic             cb_s;
  logic             ovf_s;

  // A full pipe still accepts when the output is being drained this cycle
  assign s2_load_s = !v2_r || out_ready;
  assign in_ready  = !rst && (!v1_r || s2_load_s);
  assign s1_load_s = in_valid && in_ready;
  assign sat_sel_s = SAT_EN ? in_sat : SAT_DEFAULT;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a1_r),
    .b      (b1_r),
    .op     (op1_r),
    .sgn    (sgn1_r),
    .res    (res_s),
    .sat_val(sat_val_s),
    .cb     (cb_s),
    .ovf    (ovf_s)
  );

  // Stage-2 payload: clamp only when saturation is requested and the result overflowed
  always_comb begin
    out_nxt_s.flags.cb  = cb_s;
    out_nxt_s.flags.ovf = ovf_s;
    if (sat1_r && ovf_s) begin
      out_nxt_s.result = sat_val_s;
    end else begin
      out_nxt_s.result = res_s;
    end
  end

  // Stage 1: operand and per-transaction mode capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      a1_r   <= {WIDTH{1'b0}};
      b1_r   <= {WIDTH{1'b0}};
      op1_r  <= OP_SUB;
      sgn1_r <= 1'b0;
      sat1_r <= 1'b0;
    end else if (s1_load_s) begin
      v1_r   <= 1'b1;
      a1_r   <= in_a;
      b1_r   <= in_b;
      op1_r  <= op_e'(in_op);
      sgn1_r <= in_signed;
      sat1_r <= sat_sel_s;
    end else if (s2_load_s) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= v1_r;
    end
  end

  // Stage 2: result register, held stable while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r  <= 1'b0;
      out_r <= '{result: {WIDTH{1'b0}}, flags: '{cb: 1'b0, ovf: 1'b0}};
    end else if (s2_load_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        out_r <= out_nxt_s;
      end else begin
        out_r <= out_r;
      end
    end else begin
      v2_r  <= v2_r;
      out_r <= out_r;
    end
  end

  assign out_valid  = v2_r;
  assign out_result = out_r.result;
  assign out_cb     = out_r.flags.cb;
  assign out_ovf    = out_r.flags.ovf;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, two-stage pipelined add/subtract unit; the successor to the team's fixed 4-bit combinational subtractor.
- Adds operand width generalisation, four operation modes, and signed or unsigned interpretation.
- Adds optional saturation, borrow/carry and overflow flags, and valid/ready handshakes on both sides.
- Sits between operand producers and the result consumer in the datapath; full throughput of one operation per clock.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).
- SAT_DEFAULT, 0, value assumed for per-transaction saturation when SAT_EN=0.
- SAT_EN, 1, 1 = honour in_sat port; 0 = in_sat ignored and SAT_DEFAULT used.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  unit can accept a transaction this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  operation: 0 SUB (a-b), 1 ADD (a+b), 2 RSUB (b-a), 3 ABSDIFF (|a-b|).
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_sat  input  1  1 = saturate on overflow, 0 = wrap.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_cb  output  1  unsigned carry (ADD) or borrow (SUB/RSUB/ABSDIFF: set when the minuend is less than the subtrahend under the selected signedness).
- out_ovf  output  1  result not representable in WIDTH bits under the selected signedness (before saturation).

Behaviour:
- Reset (async assert, sync release) clears both stage-valid bits; out_valid=0, out_result=0, out_cb=0, out_ovf=0.
- While rst=1: in_ready=0. In-flight transactions are discarded, not completed.
- Handshake:
  - An input transfer occurs on a clk edge when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline:
  - Stage 1 registers the operands and computes a raw (WIDTH+1)-bit sum/difference, sign- or zero-extended per in_signed.
  - Stage 2 registers result, saturation and flags.
- Latency: an accepted transaction is visible on out_* exactly 2 cycles later when out_ready stays high.
- Ready/stall rules:
  - Stage 2 loads when empty or being drained.
  - Stage 1 loads when empty or advancing.
  - in_ready = !v1 || !v2 || out_ready, so there is no bubble; back-to-back operations give 1 result per cycle.
- Stall: while out_valid && !out_ready, out_result/out_cb/out_ovf are held stable. At most 2 transactions are buffered, and ordering is preserved.
- Arithmetic, unsigned mode:
  - SUB/RSUB wrap modulo 2^WIDTH; out_cb=borrow; out_ovf=borrow.
  - ADD: out_cb=carry; out_ovf=carry.
  - Saturation clamps SUB/RSUB to 0 and ADD to 2^WIDTH-1.
- Arithmetic, signed mode:
  - out_ovf is set when the true result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Saturation clamps to the nearer bound.
  - out_cb reports the signed comparison a<b for SUB/ABSDIFF and b<a for RSUB; for ADD it is the unsigned carry out.
- ABSDIFF:
  - The result is an unsigned magnitude in WIDTH bits; it always fits, so out_ovf=0 and saturation has no effect.
  - out_cb=1 when a<b under the selected signedness.
- Per-transaction fields (in_op, in_signed, in_sat) are captured with the operands. Mixing modes in back-to-back transactions is legal.
- in_a/in_b are don't-care when in_valid=0.

Decomposition:
- Shared package addsub_pkg holds:
  - the operation encoding typedef (op_e: OP_SUB, OP_ADD, OP_RSUB, OP_ABSDIFF);
  - a packed stage-payload struct template (result, cb, ovf);
  - helper functions for signed min/max bounds at WIDTH.
- One natural sub-module: addsub_core, the combinational raw-result and flag computation for one transaction. It is instantiated in stage 1, with saturation applied in stage 2. The handshake and registers stay in addsub_pipe.

Test Plan (WIDTH=4 unless stated):
- Basic latency: unsigned SUB a=4,b=1 then a=7,b=3 back-to-back, out_ready=1 -> out_result=3 at cycle+2, then 4 at cycle+3; out_cb=0, out_ovf=0, in_ready stays 1.
- Unsigned wrap vs saturate: SUB a=1,b=4, in_sat=0 -> result 13, cb=1, ovf=1. Same with in_sat=1 -> result 0, cb=1, ovf=1.
- Signed overflow: in_signed=1, SUB a=-8 (4'b1000), b=1, in_sat=1 -> result 4'b1000 (-8), ovf=1. Then ADD a=7,b=1, in_sat=1 -> result 7, ovf=1.
- ABSDIFF and RSUB: ABSDIFF unsigned a=3,b=12 -> result 9, cb=1, ovf=0. RSUB a=2,b=9 -> result 7, cb=0.
- Backpressure: issue 3 transactions with out_ready=0 -> in_ready drops after 2 are accepted and the first result is held stable. Then release out_ready -> results drain in order at 1/cycle with no loss or duplication.
- Reset mid-operation: assert rst asynchronously (between edges) with 2 transactions in flight -> out_valid=0, out_result=0 immediately. After release, a new SUB a=5,b=2 returns 3 two cycles after acceptance, and no stale result appears.
